// File: rtl/fifo_sync_dec_if.sv
// Producer/consumer bundle for fifo_sync_dec.
// The master side drives the requests and the slave side returns data, status and write-select.
interface fifo_sync_dec_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DEPTH-1:0]  wr_sel;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, wr_sel, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, wr_sel, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_dec.sv
// Single-clock FIFO over a register array, written via a one-hot ADDR_W-to-DEPTH decoder.
// Provides occupancy, threshold flags and sticky overflow/underflow.
module fifo_sync_dec #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned AF_LEVEL = (1 << ADDR_W) - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic           clk,
  input  logic           rst,
  fifo_sync_dec_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              full_c, empty_c, wr_acc_c, rd_acc_c;
  logic [DEPTH-1:0]  wr_sel_c;

  // Status decodes of the registered occupancy.
  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign wr_acc_c = bus.wr_en && !full_c;
  assign rd_acc_c = bus.rd_en && !empty_c;
  assign wr_sel_c = wr_acc_c ? (DEPTH'(1) << wr_ptr_q) : '0;

  // Each storage word loads only when its decoder line is high.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = wr_sel_c[i] ? bus.wr_data : mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_acc_c;
    overflow_d  = overflow_q  | (bus.wr_en && full_c);
    underflow_d = underflow_q | (bus.rd_en && empty_c);
    if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc_c) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.wr_sel       = wr_sel_c;
  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
